// File: rtl/pic_pc_unit.sv
// PIC16C57 program counter and next-PC sequencer: drives the 2-level return stack,
// applies GOTO/CALL/RETLW/PCL-write/skip, and inserts the post-branch pipeline flush.
module pic_pc_unit #(
    parameter int              PC_W        = 11,
    parameter logic [PC_W-1:0] RESET_VEC   = 11'h7FF,
    parameter int              STACK_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2:0]      pc_op,
    input  logic [8:0]      k,
    input  logic [7:0]      pcl_data,
    input  logic [1:0]      pa,
    input  logic [PC_W-1:0] stack_top,
    output logic [PC_W-1:0] stack_in,
    output logic [1:0]      stack_instruction,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic [1:0]      depth,
    output logic            ovf,
    output logic            unf
);

    typedef enum logic [2:0] {
        OP_INC    = 3'd0,
        OP_GOTO   = 3'd1,
        OP_CALL   = 3'd2,
        OP_RETLW  = 3'd3,
        OP_PCL_WR = 3'd4,
        OP_SKIP   = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_PUSH = 2'd0,
        S_POP  = 2'd1,
        S_NO   = 2'd2
    } stack_cmd_t;

    localparam logic [1:0] DEPTH_MAX = 2'(STACK_DEPTH);

    op_t             eff_op;
    stack_cmd_t      cmd;
    logic [PC_W-1:0] pc_next;
    logic            flush_next;
    logic [1:0]      depth_next;
    logic            ovf_next;
    logic            unf_next;

    // A flushed slot holds a discarded fetch, so its opcode must not act.
    always_comb begin
        eff_op = flush ? OP_INC : op_t'(pc_op);
    end

    always_comb begin
        cmd = S_NO;
        if (!rst && en) begin
            case (eff_op)
                OP_CALL:  cmd = S_PUSH;
                OP_RETLW: cmd = S_POP;
                default:  cmd = S_NO;
            endcase
        end
    end

    assign stack_instruction = cmd;
    assign stack_in          = pc;

    always_comb begin
        pc_next    = pc + 1'b1;
        flush_next = 1'b1;
        depth_next = depth;
        ovf_next   = ovf;
        unf_next   = unf;
        case (eff_op)
            OP_GOTO: pc_next = PC_W'({pa, k[8:0]});
            OP_CALL: begin
                pc_next = PC_W'({pa, 1'b0, k[7:0]});
                if (depth < DEPTH_MAX) depth_next = depth + 2'd1;
                else                   ovf_next   = 1'b1;
            end
            OP_RETLW: begin
                pc_next = stack_top;
                if (depth != '0) depth_next = depth - 2'd1;
                else             unf_next   = 1'b1;
            end
            OP_PCL_WR: pc_next = PC_W'({pa, 1'b0, pcl_data});
            OP_SKIP:   flush_next = 1'b1;
            default:   flush_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_VEC;
            flush <= 1'b1;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (en) begin
            pc    <= pc_next;
            flush <= flush_next;
            depth <= depth_next;
            ovf   <= ovf_next;
            unf   <= unf_next;
        end
    end

endmodule

// File: tb/tb_pic_pc_unit.sv
// Bench for pic_pc_unit: an arithmetic reference model checked every negedge, plus
// directed vectors with hand-computed literal expectations.
module tb_pic_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  pc_op = 3'd0;
    logic [8:0]  k = '0;
    logic [7:0]  pcl_data = '0;
    logic [1:0]  pa = '0;
    logic [10:0] stack_top = '0;
    logic [10:0] stack_in;
    logic [1:0]  stack_instruction;
    logic [10:0] pc;
    logic        flush;
    logic [1:0]  depth;
    logic        ovf;
    logic        unf;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, plain integers.
    int m_pc = 2047;
    int m_flush = 1;
    int m_depth = 0;
    int m_ovf = 0;
    int m_unf = 0;

    pic_pc_unit #(.PC_W(11), .RESET_VEC(11'h7FF), .STACK_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .en(en), .pc_op(pc_op), .k(k), .pcl_data(pcl_data),
        .pa(pa), .stack_top(stack_top), .stack_in(stack_in),
        .stack_instruction(stack_instruction), .pc(pc), .flush(flush),
        .depth(depth), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 2047; m_flush = 1; m_depth = 0; m_ovf = 0; m_unf = 0;
        end else if (en) begin
            int op;
            op = m_flush ? 0 : int'(pc_op);
            m_flush = (op >= 1 && op <= 5) ? 1 : 0;
            case (op)
                1: m_pc = int'(pa) * 512 + int'(k);
                2: begin
                    m_pc = int'(pa) * 512 + (int'(k) % 256);
                    if (m_depth == 2) m_ovf = 1; else m_depth = m_depth + 1;
                end
                3: begin
                    m_pc = int'(stack_top);
                    if (m_depth == 0) m_unf = 1; else m_depth = m_depth - 1;
                end
                4: m_pc = int'(pa) * 512 + int'(pcl_data);
                default: m_pc = (m_pc + 1) % 2048;
            endcase
        end
    end

    function automatic int exp_cmd();
        if (rst || !en || m_flush != 0) return 2;
        if (pc_op == 3'd2) return 0;
        if (pc_op == 3'd3) return 1;
        return 2;
    endfunction

    always @(negedge clk) begin
        chk("pc", 16'(pc), 16'(m_pc));
        chk("flush", 16'(flush), 16'(m_flush));
        chk("depth", 16'(depth), 16'(m_depth));
        chk("ovf", 16'(ovf), 16'(m_ovf));
        chk("unf", 16'(unf), 16'(m_unf));
        chk("stack_in", 16'(stack_in), 16'(m_pc));
        chk("stack_instruction", 16'(stack_instruction), 16'(exp_cmd()));
    end

    task automatic drive(input logic [2:0] op, input logic [8:0] kk, input logic [7:0] pd,
                         input logic [1:0] p, input logic [10:0] st, input logic e);
        pc_op = op; k = kk; pcl_data = pd; pa = p; stack_top = st; en = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input logic [2:0] op, input logic [8:0] kk, input logic [7:0] pd,
                       input logic [1:0] p, input logic [10:0] st, input logic e);
        drive(op, kk, pd, p, st, e);
        tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        drive(3'd2, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        #1;
        chk("rst_pc", 16'(pc), 16'h7FF);
        chk("rst_flush", 16'(flush), 16'h1);
        chk("rst_depth", 16'(depth), 16'h0);
        chk("rst_cmd", 16'(stack_instruction), 16'h2);
        tick();
        rst = 1'b0;

        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("inc0_pc", 16'(pc), 16'h000);
        chk("inc0_flush", 16'(flush), 16'h0);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("inc2_pc", 16'(pc), 16'h002);

        cyc(3'd4, 9'h0, 8'h0F, 2'd0, 11'h0, 1'b1);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("pre_goto_pc", 16'(pc), 16'h010);
        cyc(3'd1, 9'h155, 8'h0, 2'd1, 11'h0, 1'b1);
        chk("goto_pc", 16'(pc), 16'h355);
        chk("goto_flush", 16'(flush), 16'h1);
        drive(3'd2, 9'h0AB, 8'h0, 2'd1, 11'h0, 1'b1);
        #1 chk("flushed_call_cmd", 16'(stack_instruction), 16'h2);
        tick();
        chk("flushed_call_pc", 16'(pc), 16'h356);
        chk("flushed_call_depth", 16'(depth), 16'h0);

        cyc(3'd4, 9'h0, 8'h1F, 2'd0, 11'h0, 1'b1);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        drive(3'd2, 9'h0AB, 8'h0, 2'd2, 11'h0, 1'b1);
        #1;
        chk("call_cmd", 16'(stack_instruction), 16'h0);
        chk("call_push_data", 16'(stack_in), 16'h020);
        tick();
        chk("call_pc", 16'(pc), 16'h4AB);
        chk("call_depth", 16'(depth), 16'h1);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        drive(3'd3, 9'h0, 8'h0, 2'd0, 11'h020, 1'b1);
        #1 chk("ret_cmd", 16'(stack_instruction), 16'h1);
        tick();
        chk("ret_pc", 16'(pc), 16'h020);
        chk("ret_depth", 16'(depth), 16'h0);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);

        cyc(3'd2, 9'h010, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("call1_depth", 16'(depth), 16'h1);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        cyc(3'd2, 9'h020, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("call2_depth", 16'(depth), 16'h2);
        chk("call2_ovf", 16'(ovf), 16'h0);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        cyc(3'd2, 9'h030, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("call3_depth", 16'(depth), 16'h2);
        chk("call3_ovf", 16'(ovf), 16'h1);
        chk("call3_pc", 16'(pc), 16'h030);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);

        cyc(3'd4, 9'h0, 8'hFF, 2'd3, 11'h0, 1'b1);
        chk("pcl_pc", 16'(pc), 16'h6FF);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        cyc(3'd4, 9'h0, 8'hFF, 2'd0, 11'h0, 1'b1);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("pre_skip_pc", 16'(pc), 16'h100);
        cyc(3'd5, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("skip_pc", 16'(pc), 16'h101);
        chk("skip_flush", 16'(flush), 16'h1);
        cyc(3'd6, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        cyc(3'd7, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        chk("op7_pc", 16'(pc), 16'h103);

        for (int i = 0; i < 4; i++) begin
            drive(3'd2, 9'h055, 8'h0, 2'd0, 11'h0, 1'b0);
            #1 chk("stall_cmd", 16'(stack_instruction), 16'h2);
            tick();
        end
        chk("stall_pc", 16'(pc), 16'h103);
        chk("stall_depth", 16'(depth), 16'h2);
        chk("stall_flush", 16'(flush), 16'h0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_pc", 16'(pc), 16'h7FF);
        chk("async_rst_ovf", 16'(ovf), 16'h0);
        chk("async_rst_depth", 16'(depth), 16'h0);
        tick();
        rst = 1'b0;

        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b0);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b0);
        chk("stall_flush_hold", 16'(flush), 16'h1);
        chk("stall_flush_pc", 16'(pc), 16'h7FF);
        cyc(3'd1, 9'h1FF, 8'h0, 2'd3, 11'h0, 1'b1);
        chk("post_rst_pc", 16'(pc), 16'h000);
        chk("post_rst_flush", 16'(flush), 16'h0);
        cyc(3'd3, 9'h0, 8'h0, 2'd0, 11'h123, 1'b1);
        chk("unf_flag", 16'(unf), 16'h1);
        chk("unf_pc", 16'(pc), 16'h123);
        chk("unf_depth", 16'(depth), 16'h0);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);
        cyc(3'd0, 9'h0, 8'h0, 2'd0, 11'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pic_pc_unit.md
Name: pic_pc_unit

Overview:
- Program counter and next-PC sequencer for the PIC16C57 core.
- Sits directly upstream of the 2-level return-address stack. It drives the stack's push/pop command and push data, and consumes the stack's top-of-stack output on return.
- Implements the 11-bit PC (2K words), page select via PA bits, GOTO/CALL/RETLW/PCL-write/skip, and the one-cycle pipeline flush that follows every taken change of flow.
- Tracks stack depth and flags overflow and underflow.

Parameters:
- PC_W, 11, PC and stack data width.
- RESET_VEC, 11'h7FF, PC value loaded on reset.
- STACK_DEPTH, 2, hardware stack levels used for depth and overflow tracking.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 = stall, all state held.
- pc_op  input  3  0 INC, 1 GOTO, 2 CALL, 3 RETLW, 4 PCL_WR, 5 SKIP; 6 and 7 are treated as INC.
- k  input  9  instruction literal (GOTO uses k[8:0]; CALL uses k[7:0]).
- pcl_data  input  8  ALU result written to PCL.
- pa  input  2  STATUS<6:5> page bits.
- stack_top  input  11  current top-of-stack from the stack block.
- stack_in  output  11  push data to the stack.
- stack_instruction  output  2  0 PUSH, 1 POP, 2 S_NO, matching the stack encoding.
- pc  output  11  fetch address (registered).
- flush  output  1  registered; 1 = the instruction now in execute is forced to NOP.
- depth  output  2  registered stack occupancy, 0..2.
- ovf  output  1  sticky overflow flag.
- unf  output  1  sticky underflow flag.

Behaviour:
- Reset (async, rst=1): pc=RESET_VEC (0x7FF), flush=1, depth=0, ovf=0, unf=0. stack_instruction=S_NO combinationally while rst=1.
- pc is the address being fetched. The executing instruction sits at pc-1, so the return address is pc itself.
- stack_in = pc at all times (combinational).
- Effective op: if en=0, nothing changes and stack_instruction=S_NO. If flush=1, pc_op is ignored and treated as INC with no stack operation.
- Next PC per effective op, taken at the clock edge when en=1:
  - INC: pc+1, mod 2^11; 0x7FF wraps to 0x000. flush<=0.
  - GOTO: {pa, k[8:0]}. flush<=1.
  - CALL: {pa, 1'b0, k[7:0]}. stack_instruction=PUSH. flush<=1.
  - RETLW: stack_top. stack_instruction=POP. flush<=1. stack_top is sampled in the same cycle the POP is issued.
  - PCL_WR: {pa, 1'b0, pcl_data}. flush<=1.
  - SKIP: pc+1. flush<=1, so the instruction being fetched is discarded.
- stack_instruction is combinational from rst, en, flush and pc_op. It is S_NO for every op except CALL and RETLW.
- Depth on CALL:
  - depth<2: depth+1.
  - depth==2: depth stays 2 and ovf<=1. The push still issues; the stack drops its oldest entry.
- Depth on RETLW:
  - depth>0: depth-1.
  - depth==0: depth stays 0 and unf<=1. The pop still issues and pc still loads stack_top.
- ovf and unf clear only on rst.
- Reset mid-operation: the async assert overrides any pending op immediately. The first edge after deassert performs INC from 0x7FF to 0x000, with flush=1 on that cycle, so no pc_op is honoured.
- Stall (en=0) with flush=1: flush stays 1 until the next enabled cycle.

Test Plan:
- Reset then 3 enabled INC cycles -> pc 0x7FF, 0x000, 0x001, 0x002. flush 1,0,0 and stack_instruction=S_NO throughout.
- pc=0x010, pa=2'b01, GOTO k=9'h155 -> pc=0x355 and flush=1. Next cycle pc_op=CALL (ignored) -> pc=0x356, no PUSH, flush=0.
- pc=0x020, pa=2'b10, CALL k=0xAB -> PUSH with stack_in=0x020, pc=0x4AB, depth=1. Later RETLW with stack_top=0x020 -> POP, pc=0x020, depth=0.
- Three CALLs, each separated by an INC -> depth 1, 2, 2, with ovf=1 after the third. RETLW at depth 0 after reset -> unf=1 and pc=stack_top.
- PCL_WR pcl_data=0xFF, pa=2'b11 -> pc=0x6FF. SKIP at pc=0x100 -> pc=0x101 and flush=1.
- en=0 for 4 cycles during CALL -> pc, depth and flush unchanged, stack_instruction=S_NO. Assert rst mid-stall -> pc=0x7FF immediately, before the next clock edge.
